// File: rtl/seg7_pkg.sv
// Shared types and constants for the binary-to-seven-segment display path.
// Segment patterns are active-low, bit order gfedcba.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  // Largest value representable with the given number of decimal digits.
  function automatic logic [31:0] max_decimal(input int digits);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < digits; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// One seven-segment digit decoder; dash overrides blank, blank overrides the digit.
module seg7_digit
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (dash_i)                 seg_o = SEG_DASH;
    else if (blank_i)           seg_o = SEG_BLANK;
    else if (nibble_i < 4'd10)  seg_o = SEG_TABLE[nibble_i];
  end

endmodule

// File: rtl/bin_to_seg_display.sv
// Serial double-dabble binary-to-BCD converter driving DIGITS seven-segment digits.
// HEX only changes on the LOAD edge, so the display never shows partial results.
module bin_to_seg_display
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  blank_lz,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_VAL = max_decimal(DIGITS);

  state_e                state_q, state_d;
  logic [BIN_W-1:0]      sh_q, sh_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  blank_q, blank_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [7*DIGITS-1:0]   hex_q, hex_d, seg_w;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  assign HEX  = hex_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;

  // Add-3 correction of every nibble ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic blank_w;
    assign blank_w = blank_q && (i != 0) && (bcd_q[BCD_W-1:4*i] == '0);

    seg7_digit u_digit (
      .nibble_i (bcd_q[4*i +: 4]),
      .blank_i  (blank_w),
      .dash_i   (ovf_pend_q),
      .seg_o    (seg_w[7*i +: 7])
    );
  end

  // NOTE: every next-state signal gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    blank_d    = blank_q;
    ovf_pend_d = ovf_pend_q;
    hex_d      = hex_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SHIFT;
          sh_d       = bin;
          bcd_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          blank_d    = blank_lz;
          ovf_pend_d = (32'(bin) > MAX_VAL);
          busy_d     = 1'b1;
        end
      end
      ST_SHIFT: begin
        {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
        cnt_d         = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        hex_d   = seg_w;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      blank_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      hex_q      <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      blank_q    <= blank_d;
      ovf_pend_q <= ovf_pend_d;
      hex_q      <= hex_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: doc/bin_to_seg_display.md
BIN_TO_SEG_DISPLAY -- requirements
Module: bin_to_seg_display

Interface
REQ-001 Parameter DIGITS, default 4: number of decimal digits displayed; legal range 1..9.
REQ-002 Parameter BIN_W, default 14: width of the binary input; legal range 4..30.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to convert bin; sampled on the rising edge.
REQ-006 bin  input  BIN_W  unsigned value to display; sampled only on the edge that accepts start.
REQ-007 blank_lz  input  1  leading-zero blanking enable; sampled with bin.
REQ-008 HEX  output  7*DIGITS  active-low segments; digit i occupies bits [7i+6:7i]; digit 0 is the least significant; bit order gfedcba.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse when HEX has just been updated.
REQ-011 ovf  output  1  registered; high while the displayed result came from an out-of-range input.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and LOAD.
- IDLE->SHIFT on start.
- SHIFT->LOAD after BIN_W iterations.
- LOAD->IDLE unconditionally.
REQ-013 In IDLE, start=1 SHALL capture bin into the shift register and blank_lz into a flag, clear the BCD accumulator to zero, and load the iteration counter with BIN_W.
REQ-014 start SHALL be ignored in SHIFT and LOAD; no queueing occurs.
REQ-015 Each SHIFT cycle SHALL perform one double-dabble iteration:
- add 3 to every BCD nibble >= 5;
- then shift {bcd, bin_reg} left by one;
- decrement the counter.
REQ-016 The BCD accumulator SHALL be 4*DIGITS bits wide; bits shifted out of its top SHALL be discarded.
REQ-017 In the IDLE cycle that accepts start, a range check SHALL set an ovf_pending flag if bin > 10^DIGITS-1; the comparison constant is computed at elaboration.
REQ-018 Latency: if start is accepted at edge k, the HEX, ovf and done registers SHALL update at edge k+BIN_W+1; busy SHALL be high from edge k to edge k+BIN_W+1.
REQ-019 done SHALL be high for exactly the one cycle following the LOAD edge; a new start is accepted in that same cycle.
REQ-020 HEX SHALL hold its last loaded value at all times except the LOAD edge, so there is no intermediate flicker.
REQ-021 Per-digit decode SHALL use these active-low codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
REQ-022 Any nibble >= 10 SHALL decode to 1111111 (all segments off), never X.
REQ-023 With the blank_lz flag set, every digit above the most significant non-zero digit SHALL show 1111111; digit 0 is never blanked, so a value of 0 shows a single "0".
REQ-024 On overflow, every digit SHALL show 0111111 (dash, segment g only) and ovf SHALL be 1; otherwise ovf SHALL be 0.
REQ-025 Overflow SHALL NOT change latency: the SHIFT iterations still run.
REQ-026 Start pulses of any length SHALL behave as one request; a long start pulse re-triggers only when it is seen in IDLE.

Reset
REQ-027 rst_n low SHALL immediately, without waiting for clk, force:
- state=IDLE;
- busy=0, done=0, ovf=0;
- every HEX digit = 1111111 (all segments off);
- counter, BCD accumulator and flags = 0.
REQ-028 Reset asserted mid-conversion SHALL abort it with no LOAD and no done pulse.
REQ-029 After rst_n rises, the first start SHALL be accepted on the first rising clock edge that sees it.

Structure
REQ-030 Package seg7_pkg SHALL hold:
- the FSM state enum;
- the constants SEG_BLANK=1111111 and SEG_DASH=0111111;
- the 10-entry digit pattern table.
REQ-031 Sub-module seg7_digit SHALL be purely combinational, instantiated DIGITS times via generate.
- Inputs: 4-bit nibble, blank, dash.
- Output: 7-bit active-low pattern.
- Priority: dash > blank > decode.
REQ-032 The counter width SHALL be $clog2(BIN_W+1).

Verification (DIGITS=4, BIN_W=14 unless stated)
REQ-033 Test: bin=1234, blank_lz=0, start 1 cycle. Required: busy for 15 cycles, then done pulse; HEX digits 3..0 = 1, 2, 3, 4 codes; ovf=0.
REQ-034 Test: bin=7, blank_lz=1. Required: digits 3..1 = 1111111, digit 0 = 1111000. Then bin=0 with blank_lz=1: only digit 0 lit, showing 1000000.
REQ-035 Test: bin=10000, and separately bin=16383. Required: all digits 0111111 and ovf=1. Then bin=9999: all digits 0011000 and ovf=0.
REQ-036 Test: start held high for 40 cycles with bin=42. Required: conversions complete at 16-cycle intervals. Also: bin changed mid-conversion does not affect the result.
REQ-037 Test: rst_n pulsed low at cycle 8 of a conversion. Required: HEX=all 1111111 with no clock edge needed, busy=0, no done pulse; the next start converts correctly.
REQ-038 Test: DIGITS=6, BIN_W=20 sweep of 0, 1, 999999, 1000000 and random values, checked against a reference model. Required: each value shows its decimal digits; 1000000 shows all dashes with ovf=1.
